// File: rtl/net_weight_loader.sv
// net_weight_loader: streams layer-tagged weight words from memory in address order,
// absorbing the one-cycle read latency with a 2-entry skid buffer.
module net_weight_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int LAYER_WIDTH = 2,
  parameter int NUM_LAYERS  = 3,
  parameter int N0          = 2,
  parameter int N1          = 32,
  parameter int N2          = 32,
  parameter int N3          = 3,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_mem_rd,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  output logic                   o_weight_valid,
  input  logic                   i_weight_ready,
  output logic [DATA_WIDTH-1:0]  o_weight,
  output logic [LAYER_WIDTH-1:0] o_weight_layer,
  output logic                   o_bias,
  output logic                   o_busy,
  output logic                   o_done
);
  localparam int W = N1 * (N0 + 1) + (NUM_LAYERS > 1 ? N2 * (N1 + 1) : 0) + (NUM_LAYERS > 2 ? N3 * (N2 + 1) : 0);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  function automatic logic [ADDR_WIDTH-1:0] nodes(input int l);
    return ADDR_WIDTH'(l == 0 ? N0 : l == 1 ? N1 : l == 2 ? N2 : N3);
  endfunction
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, word_q, word_d, node_q, node_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic [DATA_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
  logic [1:0] cnt_q, cnt_d, mid;
  logic inflight_q, inflight_d;
  logic clr, xfer, pop, push, last_word, last_node, last_addr;
  // The head beat bypasses the buffer straight from memory when nothing is queued;
  // tag and bias come from output-side counters since beats leave in address order.
  always_comb begin
    clr = i_abort && state_q != IDLE;
    o_busy = state_q == FETCH || state_q == DRAIN;
    o_done = state_q == DONE;
    o_weight_valid = cnt_q != 2'd0 || inflight_q;
    xfer = o_weight_valid && i_weight_ready;
    o_weight = cnt_q != 2'd0 ? b0_q : inflight_q ? i_mem_data : '0;
    o_weight_layer = o_weight_valid ? layer_q + LAYER_WIDTH'(1) : '0;
    last_word = word_q == nodes(int'(layer_q));
    last_node = node_q == nodes(int'(layer_q) + 1) - ADDR_WIDTH'(1);
    o_bias = o_weight_valid && last_word;
    o_mem_rd = state_q == FETCH && cnt_q + 2'(inflight_q) - 2'(xfer) < 2'd2;
    o_mem_addr = addr_q;
    last_addr = addr_q == ADDR_WIDTH'(W - 1);
    pop = xfer && cnt_q != 2'd0;
    push = inflight_q && !(xfer && cnt_q == 2'd0);
    mid = cnt_q - 2'(pop);
    b0_d = push && mid == 2'd0 ? i_mem_data : pop ? b1_q : b0_q;
    b1_d = push && mid == 2'd1 ? i_mem_data : b1_q;
    cnt_d = clr ? 2'd0 : mid + 2'(push);
    inflight_d = o_mem_rd && !clr;
    addr_d = clr ? '0 : o_mem_rd ? (last_addr ? '0 : addr_q + ADDR_WIDTH'(1)) : addr_q;
    word_d = clr ? '0 : xfer ? (last_word ? '0 : word_q + ADDR_WIDTH'(1)) : word_q;
    node_d = clr ? '0 : xfer && last_word ? (last_node ? '0 : node_q + ADDR_WIDTH'(1)) : node_q;
    layer_d = clr ? '0 : xfer && last_word && last_node ?
              (layer_q == LAYER_WIDTH'(NUM_LAYERS - 1) ? '0 : layer_q + LAYER_WIDTH'(1)) : layer_q;
    state_d = clr ? IDLE :
              state_q == IDLE  ? (i_start && !i_abort ? FETCH : IDLE) :
              state_q == FETCH ? (o_mem_rd && last_addr ? DRAIN : FETCH) :
              state_q == DRAIN ? (cnt_d == 2'd0 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      word_q <= '0;
      node_q <= '0;
      layer_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      cnt_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      word_q <= word_d;
      node_q <= node_d;
      layer_q <= layer_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      cnt_q <= cnt_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: doc/net_weight_loader.md
NET_WEIGHT_LOADER -- requirements
Module: net_weight_loader

Interface
REQ-001 DATA_WIDTH, 32, weight word width.
REQ-002 LAYER_WIDTH, 2, width of layer tag; layer code 0 reserved for "none".
REQ-003 NUM_LAYERS, 3, number of weighted layers, 1..(2**LAYER_WIDTH)-1.
REQ-004 N0 / N1 / N2 / N3, 2 / 32 / 32 / 3, node counts: N0 input nodes, Nl nodes of layer l; only N0..N(NUM_LAYERS) used.
REQ-005 ADDR_WIDTH, 12, weight memory address width.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 i_start  in  1  start one full weight-load pass.
REQ-009 i_abort  in  1  cancel the current pass.
REQ-010 o_mem_rd  out  1  memory read strobe.
REQ-011 o_mem_addr  out  ADDR_WIDTH  memory read address.
REQ-012 i_mem_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after o_mem_rd.
REQ-013 o_weight_valid  out  1  weight beat valid.
REQ-014 i_weight_ready  in  1  downstream accepts beat.
REQ-015 o_weight  out  DATA_WIDTH  weight word.
REQ-016 o_weight_layer  out  LAYER_WIDTH  layer tag of current beat, 0 when no beat.
REQ-017 o_bias  out  1  beat is the bias (last word) of its node.
REQ-018 o_busy  out  1  pass in progress.
REQ-019 o_done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-020 Memory layout SHALL be contiguous from address 0, layer-major, node-major within layer: node k of layer l occupies N(l-1)+1 words (N(l-1) weights, then bias); layer l+1 starts immediately after layer l.
REQ-021 Total beats W SHALL equal sum over l of Nl*(N(l-1)+1); defaults give 96+1056+99=1251.
REQ-022 States SHALL be IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on i_start; FETCH->DRAIN after address W-1 issued; DRAIN->DONE when buffer empty; DONE->IDLE after one cycle with o_done=1.
REQ-023 i_start SHALL be ignored while o_busy=1; o_busy SHALL be 1 in FETCH and DRAIN.
REQ-024 Addresses SHALL be issued 0..W-1 in strict increasing order, each exactly once per pass.
REQ-025 A beat SHALL transfer on a cycle with o_weight_valid=1 and i_weight_ready=1; o_weight, o_weight_layer, o_bias SHALL hold stable while o_weight_valid=1 and i_weight_ready=0.
REQ-026 A 2-entry skid buffer SHALL absorb read latency; o_mem_rd SHALL assert only when buffered plus in-flight words would not exceed 2 after that cycle's transfer; no word lost or duplicated.
REQ-027 With i_weight_ready held 1: i_start sampled at edge T -> o_mem_rd addr 0 in cycle T+1, first beat valid in cycle T+2, one beat per cycle, last beat in cycle T+W+1, o_done in cycle T+W+2.
REQ-028 Layer tag SHALL be l (1..NUM_LAYERS) for every beat of layer l; o_bias=1 on every (N(l-1)+1)-th beat of layer l.
REQ-029 Layer/node/word counters SHALL wrap to 0 at their bounds; no counter SHALL exceed its bound.
REQ-030 i_abort (any non-IDLE state) SHALL, next cycle, force state IDLE, o_weight_valid=0, o_mem_rd=0, buffer flushed, counters 0, no o_done; read data returning after abort SHALL be discarded; i_abort in IDLE has no effect; i_abort beats i_start in the same cycle.

Reset
REQ-031 On rst=1, asynchronously: state IDLE, o_mem_rd=0, o_mem_addr=0, o_weight_valid=0, o_weight=0, o_weight_layer=0, o_bias=0, o_busy=0, o_done=0, buffer empty, counters 0.
REQ-032 Reset mid-pass SHALL discard the pass; first i_start after rst release SHALL restart from address 0.

Verification
REQ-033 Defaults, ready=1, memory word=address -> 1251 beats, o_weight=0..1250, tags 96x1, 1056x2, 99x3, o_bias every 3rd/33rd/33rd, o_done at T+1253.
REQ-034 Ready pseudo-random 50% -> identical beat sequence to REQ-033, outputs stable during stalls, never more than 2 words outstanding.
REQ-035 i_abort at beat 500 (layer 2) -> next cycle o_weight_valid=0, o_busy=0, no o_done; new i_start restarts at address 0 with 1251 beats.
REQ-036 i_start pulsed at beat 100 and in DONE cycle -> ignored, exactly 1251 beats, single o_done.
REQ-037 rst asserted mid-layer 3 -> all outputs at REQ-031 values immediately, without clock edge.
REQ-038 NUM_LAYERS=1, N0=1, N1=1 -> 2 beats, tag 1, o_bias on second, o_done at T+4.
